grant_burst_mux: RTL and testbench
==================================

Name: grant_burst_mux

Overview:
- Sits directly downstream of the round-robin arbiter and consumes its registered one-hot grant vector.
- Locks the granted requester as owner for a multi-beat burst.
- Muxes that requester's payload onto a single valid/ready output channel and pops one beat per handshake.
- Releases ownership after the final beat; exports busy so integration can mask arbiter requests while a burst is in flight.

Parameters:
- requesters, 4, number of requesters; must equal the arbiter's requesters.
- DATA_W, 32, payload width per requester.
- MAX_BEATS, 16, maximum burst length; power of two, >=2; BEAT_W = $clog2(MAX_BEATS).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- chosen  input  requesters  one-hot grant from arbiter; all-zero means no grant this cycle.
- req_data  input  requesters*DATA_W  flattened payloads; slice i = req_data[i*DATA_W +: DATA_W].
- req_beats  input  requesters*BEAT_W  per-requester burst length minus 1; slice i, same packing.
- req_pop  output  requesters  one-hot, 1-cycle pulse when the owner's current beat is consumed.
- out_valid  output  1  beat available on out_data.
- out_ready  input  1  downstream accepts beat.
- out_data  output  DATA_W  owner's current payload.
- out_id  output  $clog2(requesters)  owner index.
- out_last  output  1  high with the final beat of a burst.
- busy  output  1  burst in flight (state XFER).
- done  output  1  registered 1-cycle pulse the cycle after the final handshake.
- grant_drop  output  1  registered 1-cycle pulse: a nonzero grant arrived while busy and was discarded.

Behaviour:
- Reset (async, active-high): state=IDLE; owner=0, beats_left=0; all outputs 0. Reset mid-burst aborts silently: no done, no further req_pop.
- FSM states: IDLE, XFER.
- IDLE:
  - chosen != 0 → owner = index of the set bit; beats_left = req_beats slice of owner; state→XFER.
  - out_valid rises the next cycle, so latency is 1 cycle from grant to first beat.
- XFER:
  - out_valid=1; out_id=owner.
  - out_data = req_data slice of owner, combinational from the registered owner.
  - out_last = (beats_left==0).
- Handshake (out_valid && out_ready):
  - req_pop[owner]=1 in the same cycle, combinational.
  - beats_left decrements.
  - If beats_left was 0: state→IDLE and done=1 on the next cycle.
- No handshake: out_valid, out_data slice selection, out_id and out_last are held. The upstream requester must hold its payload stable until popped. out_valid never drops mid-burst.
- Bursts are back-to-back capable: a grant in the cycle busy deasserts (done cycle) is accepted, so the minimum gap is 1 idle cycle.
- Grant while in XFER: ignored, grant_drop=1 next cycle, owner unchanged. Integration masks the arbiter request with ~busy to avoid this.
- req_beats=0 gives a single-beat burst: out_last is high on the first beat.
- req_beats=MAX_BEATS-1 gives MAX_BEATS beats.
- beats_left is BEAT_W bits wide and never wraps: the decrement is blocked at 0.
- Requester deasserts its request mid-burst: no effect on this block; the burst completes.

Optional Feature:
- Macro: GRANT_ONEHOT_CHECK_EN.
- Defined:
  - A nonzero, non-one-hot chosen in IDLE is rejected: no burst starts, state stays IDLE.
  - New output grant_err (1 bit) pulses 1 cycle, registered.
  - An immediate assertion fires in simulation.
- Not defined:
  - The lowest-index set bit wins.
  - grant_err port is absent.

Decomposition:
- Package grant_burst_pkg:
  - state enum state_e {IDLE, XFER}.
  - function onehot_to_idx (lowest set bit).
  - function is_onehot.
- One sub-module, natural and reusable: onehot_encoder (requesters → index plus valid/multi flags).

Test Plan:
- Reset, then chosen=4'b0100 with req_beats[2]=3 and out_ready=1 → out_valid next cycle; 4 beats with out_id=2; req_pop=4'b0100 each beat; out_last on beat 4; done 1 cycle later.
- Same burst with out_ready toggling 1,0,0,1,1,0,1 → out_data held while stalled; exactly 4 pops; out_last only on the 4th accepted beat.
- chosen=4'b0001 with req_beats[0]=0 → single beat with out_last=1; then chosen=4'b1000 in the done cycle → new burst with out_id=3 and no drop.
- During a 16-beat burst from requester 1, pulse chosen=4'b0010 → grant_drop=1 once; owner stays 1; 16 beats total.
- Assert reset at beat 2 of a 4-beat burst → all outputs 0 asynchronously; no done; the next grant starts cleanly.
- With GRANT_ONEHOT_CHECK_EN: chosen=4'b0110 → grant_err pulse, busy stays 0. Without the macro: owner=1.

Source files
------------

// File: rtl/grant_burst_pkg.sv
// ============================================================================
// grant_burst_pkg : shared state encoding and one-hot helpers for grant_burst_mux
// Revision: 1.0
// ============================================================================
`default_nettype none

package grant_burst_pkg;

  localparam int MAX_REQ = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_REQ-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/grant_burst_mux_onehot_encoder.sv
// ============================================================================
// onehot_encoder : grant vector to index, with any-bit-set and multi-bit flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module onehot_encoder
  import grant_burst_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid,
  output logic             o_multi
);

  logic [MAX_REQ-1:0] w_vec;

  assign w_vec   = MAX_REQ'(i_vec);
  assign o_idx   = IDX_W'(onehot_to_idx(w_vec));
  assign o_valid = |i_vec;
  assign o_multi = o_valid && !is_onehot(w_vec);

endmodule

`default_nettype wire

// File: rtl/grant_burst_mux.sv
// ============================================================================
// grant_burst_mux : locks an arbiter grant for a multi-beat burst and muxes
//                   the owner's payload onto one valid/ready channel.
// Optional macro : GRANT_ONEHOT_CHECK_EN (reject non-one-hot grants, grant_err)
// Revision: 1.0
// ============================================================================
`default_nettype none

module grant_burst_mux
  import grant_burst_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int DATA_W     = 32,
  parameter int MAX_BEATS  = 16,
  parameter int BEAT_W     = $clog2(MAX_BEATS),
  parameter int IDX_W      = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [REQUESTERS-1:0]        chosen,
  input  logic [REQUESTERS*DATA_W-1:0] req_data,
  input  logic [REQUESTERS*BEAT_W-1:0] req_beats,
  output logic [REQUESTERS-1:0]        req_pop,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [IDX_W-1:0]             out_id,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
`ifdef GRANT_ONEHOT_CHECK_EN
  output logic                         grant_err,
`endif
  output logic                         grant_drop
);

  state_e            r_state, w_state_n;
  logic [IDX_W-1:0]  r_owner, w_owner_n;
  logic [BEAT_W-1:0] r_beats_left, w_beats_n;
  logic              r_done, w_done_n;
  logic              r_drop, w_drop_n;
  logic              r_err, w_err_n;

  logic [IDX_W-1:0]  w_enc_idx;
  logic              w_enc_valid;
  logic              w_enc_multi;
  logic              w_start;
  logic              w_busy;
  logic              w_hs;

  onehot_encoder #(
    .N     (REQUESTERS),
    .IDX_W (IDX_W)
  ) u_enc (
    .i_vec   (chosen),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid),
    .o_multi (w_enc_multi)
  );

  assign w_busy = (r_state == XFER);
  assign w_hs   = w_busy && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_beats_left <= '0;
      r_done       <= 1'b0;
      r_drop       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_owner      <= w_owner_n;
      r_beats_left <= w_beats_n;
      r_done       <= w_done_n;
      r_drop       <= w_drop_n;
      r_err        <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_owner_n = r_owner;
    w_beats_n = r_beats_left;
    w_done_n  = 1'b0;
    w_drop_n  = 1'b0;
    w_err_n   = 1'b0;
    w_start   = 1'b0;
    unique case (r_state)
      IDLE: begin
`ifdef GRANT_ONEHOT_CHECK_EN
        w_start = w_enc_valid && !w_enc_multi;
        w_err_n = w_enc_multi;
`else
        w_start = w_enc_valid;
`endif
        if (w_start) begin
          w_owner_n = w_enc_idx;
          w_beats_n = req_beats[w_enc_idx*BEAT_W +: BEAT_W];
          w_state_n = XFER;
        end
      end
      XFER: begin
        w_drop_n = |chosen;
        if (w_hs) begin
          // Final beat leaves beats_left at 0 rather than wrapping.
          if (r_beats_left == '0) begin
            w_state_n = IDLE;
            w_done_n  = 1'b1;
          end else begin
            w_beats_n = r_beats_left - 1'b1;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Data is gated so every output reads zero outside a burst, including reset.
  assign out_valid  = w_busy;
  assign out_data   = w_busy ? req_data[r_owner*DATA_W +: DATA_W] : '0;
  assign out_id     = w_busy ? r_owner : '0;
  assign out_last   = w_busy && (r_beats_left == '0);
  assign req_pop    = w_hs ? (REQUESTERS'(1) << r_owner) : '0;
  assign busy       = w_busy;
  assign done       = r_done;
  assign grant_drop = r_drop;

`ifdef GRANT_ONEHOT_CHECK_EN
  assign grant_err = r_err;

  always @(posedge clk) begin
    if (!reset && r_state == IDLE) begin
      a_grant_onehot: assert (!w_enc_multi);
    end
  end
`else
  logic w_unused;
  assign w_unused = r_err ^ w_enc_multi;
`endif

endmodule

`default_nettype wire

// File: tb/tb_grant_burst_mux.sv
// ============================================================================
// tb_grant_burst_mux : directed table-driven bench for grant_burst_mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_grant_burst_mux;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    chosen;
  logic [N*DW-1:0] req_data;
  logic [N*BW-1:0] req_beats;
  logic [N-1:0]    req_pop;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            grant_drop;

  grant_burst_mux dut (
    .clk        (clk),
    .reset      (reset),
    .chosen     (chosen),
    .req_data   (req_data),
    .req_beats  (req_beats),
    .req_pop    (req_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .grant_drop (grant_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         clr;
    logic [N-1:0] ch;
    logic         rdy;
    logic         v;
    logic [IW-1:0] id;
    logic         last;
    logic [N-1:0] pop;
    logic         dn;
    logic         drop;
    int           beat;
  } vec_t;

  int           errors = 0;
  int           checks = 0;
  int           cnt [N];
  logic [N-1:0] seen_pop = '0;
  vec_t         tv [22];

  // Upstream payload for requester i after b pops.
  function automatic logic [DW-1:0] pay(input int i, input int b);
    return 32'hD000_0000 | (32'(i) << 8) | 32'(b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pay(i, cnt[i]);
  endtask

  task automatic step(input vec_t t);
    @(negedge clk);
    for (int i = 0; i < N; i++) if (seen_pop[i]) cnt[i]++;
    if (t.clr) for (int i = 0; i < N; i++) cnt[i] = 0;
    refresh();
    chosen    = t.ch;
    out_ready = t.rdy;
    #1;
    chk("valid", 64'(out_valid), 64'(t.v));
    chk("busy",  64'(busy),      64'(t.v));
    chk("id",    64'(out_id),    64'(t.id));
    chk("last",  64'(out_last),  64'(t.last));
    chk("pop",   64'(req_pop),   64'(t.pop));
    chk("done",  64'(done),      64'(t.dn));
    chk("drop",  64'(grant_drop), 64'(t.drop));
    chk("data",  64'(out_data),  t.v ? 64'(pay(int'(t.id), t.beat)) : 64'd0);
    seen_pop = req_pop;
  endtask

  function automatic vec_t mk(input logic clr, input logic [N-1:0] ch, input logic rdy,
                              input logic v, input int id, input logic last,
                              input logic [N-1:0] pop, input logic dn, input logic drop,
                              input int beat);
    vec_t t;
    t.clr = clr; t.ch = ch; t.rdy = rdy; t.v = v; t.id = IW'(id); t.last = last;
    t.pop = pop; t.dn = dn; t.drop = drop; t.beat = beat;
    return t;
  endfunction

  initial begin
    vec_t t;
    reset     = 1'b1;
    chosen    = '0;
    out_ready = 1'b0;
    req_beats = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    refresh();

    //             clr  ch       rdy v  id last pop      dn drop beat
    tv[0]  = mk(1'b1, 4'b0100, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
    tv[1]  = mk(1'b0, 4'b0000, 1, 1, 2, 0, 4'b0100, 0, 0, 0);
    tv[2]  = mk(1'b0, 4'b0000, 1, 1, 2, 0, 4'b0100, 0, 0, 1);
    tv[3]  = mk(1'b0, 4'b0000, 1, 1, 2, 0, 4'b0100, 0, 0, 2);
    tv[4]  = mk(1'b0, 4'b0000, 1, 1, 2, 1, 4'b0100, 0, 0, 3);
    tv[5]  = mk(1'b0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
    tv[6]  = mk(1'b0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
    tv[7]  = mk(1'b1, 4'b0100, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    tv[8]  = mk(1'b0, 4'b0000, 1, 1, 2, 0, 4'b0100, 0, 0, 0);
    tv[9]  = mk(1'b0, 4'b0000, 0, 1, 2, 0, 4'b0000, 0, 0, 1);
    tv[10] = mk(1'b0, 4'b0000, 0, 1, 2, 0, 4'b0000, 0, 0, 1);
    tv[11] = mk(1'b0, 4'b0000, 1, 1, 2, 0, 4'b0100, 0, 0, 1);
    tv[12] = mk(1'b0, 4'b0000, 1, 1, 2, 0, 4'b0100, 0, 0, 2);
    tv[13] = mk(1'b0, 4'b0000, 0, 1, 2, 1, 4'b0000, 0, 0, 3);
    tv[14] = mk(1'b0, 4'b0000, 1, 1, 2, 1, 4'b0100, 0, 0, 3);
    tv[15] = mk(1'b0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
    tv[16] = mk(1'b1, 4'b0001, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
    tv[17] = mk(1'b0, 4'b0000, 1, 1, 0, 1, 4'b0001, 0, 0, 0);
    tv[18] = mk(1'b0, 4'b1000, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
    tv[19] = mk(1'b0, 4'b0000, 1, 1, 3, 0, 4'b1000, 0, 0, 0);
    tv[20] = mk(1'b0, 4'b0000, 1, 1, 3, 1, 4'b1000, 0, 0, 1);
    tv[21] = mk(1'b0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0, 0);

    req_beats[2*BW +: BW] = 4'd3;
    req_beats[0*BW +: BW] = 4'd0;
    req_beats[3*BW +: BW] = 4'd1;
    req_beats[1*BW +: BW] = 4'd15;

    // Reset state
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_drop",  64'(grant_drop), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 22; k++) step(tv[k]);

    // 16-beat burst from requester 1 with a stray grant at beat 5
    step(mk(1'b1, 4'b0010, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
    for (int b = 0; b < 16; b++) begin
      t = mk(1'b0, (b == 5) ? 4'b0010 : 4'b0000, 1, 1, 1, (b == 15), 4'b0010, 0, (b == 6), b);
      step(t);
    end
    step(mk(1'b0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0, 0));
    step(mk(1'b0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0, 0));

    // Async reset during beat 2 of a 4-beat burst
    step(mk(1'b1, 4'b0100, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
    step(mk(1'b0, 4'b0000, 1, 1, 2, 0, 4'b0100, 0, 0, 0));
    step(mk(1'b0, 4'b0000, 1, 1, 2, 0, 4'b0100, 0, 0, 1));
    @(negedge clk);
    #2;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy",  64'(busy),      64'd0);
    chk("arst_pop",   64'(req_pop),   64'd0);
    chk("arst_last",  64'(out_last),  64'd0);
    chk("arst_id",    64'(out_id),    64'd0);
    chk("arst_data",  64'(out_data),  64'd0);
    @(negedge clk);
    reset    = 1'b0;
    seen_pop = '0;
    step(mk(1'b0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
    step(mk(1'b0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
    step(mk(1'b1, 4'b0001, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
    step(mk(1'b0, 4'b0000, 1, 1, 0, 1, 4'b0001, 0, 0, 0));
    step(mk(1'b0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0, 0));

    // Non-one-hot grant: lowest set bit (requester 1) owns a 1-beat burst
    req_beats[1*BW +: BW] = 4'd0;
    step(mk(1'b1, 4'b0110, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
    step(mk(1'b0, 4'b0000, 1, 1, 1, 1, 4'b0010, 0, 0, 0));
    step(mk(1'b0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
